sprite_frame_scheduler: RTL

//  Tear-free position/visibility controller for the sprite generators feeding the MTL pixel path.

---
 rtl/sprite_sched_pkg.sv | 33 +++
 rtl/sprite_sched_if.sv | 26 ++
 rtl/sprite_cmd_fifo.sv | 52 +++++
 rtl/sprite_frame_scheduler.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sprite_sched_pkg.sv
// Shared types for the sprite frame scheduler: command record, FSM encoding, clamp helpers.
package sprite_sched_pkg;

    localparam int X_W  = 11;
    localparam int Y_W  = 10;
    localparam int ID_W = 8;    // wide enough to hold any iCmdId for up to 256 slots

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_BLANK  = 2'd2;

    typedef enum logic [1:0] {
        S_ACTIVE = ST_ACTIVE,
        S_COMMIT = ST_COMMIT,
        S_BLANK  = ST_BLANK
    } sched_state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
        logic            vis;
    } sprite_cmd_t;

    function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v, input logic [X_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] v, input logic [Y_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sprite_sched_if.sv
// Sprite-update command channel between the SPI/PIC32 decoder (master) and the scheduler (slave).
interface sprite_sched_if
    import sprite_sched_pkg::*;
#(
    parameter int unsigned N_SPRITES = 4
);
    localparam int unsigned ID_BITS = $clog2(N_SPRITES);

    logic               iCmdValid;
    logic               oCmdReady;
    logic [ID_BITS-1:0] iCmdId;
    logic [X_W-1:0]     iCmdX;
    logic [Y_W-1:0]     iCmdY;
    logic               iCmdVis;

    modport master (
        output iCmdValid, iCmdId, iCmdX, iCmdY, iCmdVis,
        input  oCmdReady
    );

    modport slave (
        input  iCmdValid, iCmdId, iCmdX, iCmdY, iCmdVis,
        output oCmdReady
    );

endinterface

// File: rtl/sprite_cmd_fifo.sv
// Command FIFO for sprite updates; registered occupancy count drives full/empty.
module sprite_cmd_fifo
    import sprite_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        push,
    input  sprite_cmd_t push_data,
    input  logic        pop,
    output sprite_cmd_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    sprite_cmd_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Tear-free sprite position/visibility scheduler: FIFO -> shadow -> active commit in vertical blanking.
// Optional SPRITE_SCHED_FRAME_CNT_EN adds oFrameCnt, a count of commit cycles.
module sprite_frame_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int unsigned N_SPRITES  = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned X_MAX      = 799,
    parameter int unsigned Y_MAX      = 479
) (
    input  logic                     iCLK,
    input  logic                     iRST_n,
    sprite_sched_if.slave            cmd,
    input  logic                     iEndFrame,
    input  logic                     iNewFrame,
    output logic [N_SPRITES*X_W-1:0] oX0,
    output logic [N_SPRITES*Y_W-1:0] oY0,
    output logic [N_SPRITES-1:0]     oVisible,
    output logic                     oCommit,
    output logic                     oCmdErr
`ifdef SPRITE_SCHED_FRAME_CNT_EN
    ,
    output logic [15:0]              oFrameCnt
`endif
);

    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    sched_state_t         state;
    sched_state_t         state_nxt;
    sprite_cmd_t          push_cmd;
    sprite_cmd_t          pop_cmd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_valid;
    logic                 commit_any;

    logic [X_W-1:0]       shadow_x [N_SPRITES];
    logic [Y_W-1:0]       shadow_y [N_SPRITES];
    logic [N_SPRITES-1:0] shadow_v;
    logic [X_W-1:0]       act_x    [N_SPRITES];
    logic [Y_W-1:0]       act_y    [N_SPRITES];
    logic [N_SPRITES-1:0] act_v;
    logic [N_SPRITES-1:0] dirty;

    assign cmd.oCmdReady = !fifo_full;
    assign push_cmd      = '{id: ID_W'(cmd.iCmdId), x: cmd.iCmdX, y: cmd.iCmdY, vis: cmd.iCmdVis};
    assign pop_valid     = !fifo_empty && (state != S_COMMIT);

    sprite_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .push      (cmd.iCmdValid),
        .push_data (push_cmd),
        .pop       (pop_valid),
        .pop_data  (pop_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_ACTIVE: if (iEndFrame) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_BLANK;
            S_BLANK: begin
                if (iEndFrame)      state_nxt = S_COMMIT;
                else if (iNewFrame) state_nxt = S_ACTIVE;
            end
            default:  state_nxt = S_ACTIVE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= S_ACTIVE;
            dirty      <= '0;
            shadow_v   <= '0;
            act_v      <= '0;
            commit_any <= 1'b0;
            oCmdErr    <= 1'b0;
            for (int unsigned i = 0; i < N_SPRITES; i++) begin
                shadow_x[i] <= '0;
                shadow_y[i] <= '0;
                act_x[i]    <= '0;
                act_y[i]    <= '0;
            end
        end else begin
            state      <= state_nxt;
            commit_any <= (state == S_COMMIT) && (|dirty);
            if (state == S_COMMIT) begin
                for (int unsigned i = 0; i < N_SPRITES; i++) begin
                    if (dirty[i]) begin
                        act_x[i] <= shadow_x[i];
                        act_y[i] <= shadow_y[i];
                        act_v[i] <= shadow_v[i];
                    end
                end
                dirty <= '0;
            end else if (pop_valid) begin
                if (pop_cmd.id >= ID_W'(N_SPRITES)) begin
                    oCmdErr <= 1'b1;
                end else begin
                    for (int unsigned i = 0; i < N_SPRITES; i++) begin
                        if (pop_cmd.id == ID_W'(i)) begin
                            shadow_x[i] <= clamp_x(pop_cmd.x, X_LIM);
                            shadow_y[i] <= clamp_y(pop_cmd.y, Y_LIM);
                            shadow_v[i] <= pop_cmd.vis;
                            dirty[i]    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output register: the active set reaches the pins one cycle after the commit cycle,
    // aligned with the oCommit pulse.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oX0      <= '0;
            oY0      <= '0;
            oVisible <= '0;
            oCommit  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_SPRITES; i++) begin
                oX0[X_W*i +: X_W] <= act_x[i];
                oY0[Y_W*i +: Y_W] <= act_y[i];
            end
            oVisible <= act_v;
            oCommit  <= commit_any;
        end
    end

`ifdef SPRITE_SCHED_FRAME_CNT_EN
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)                oFrameCnt <= '0;
        else if (state == S_COMMIT) oFrameCnt <= oFrameCnt + 16'd1;
    end
`endif

endmodule
